alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Control FSM that sequences one register-to-register ALU instruction through data_path.
- Drives the one-hot register out/in strobes, Yin, ZHighin/Zlowin, Zhighout/Zlowout, HIin/Loin and the 5-bit op code, one bus transfer per cycle.
- Replaces hand-written per-instruction bench sequences; later sits under the instruction-decode control unit.

Parameters:
NREG, 16, number of general registers (width of the one-hot strobe buses)
OPW, 5, ALU op-code width

Ports:
Clock  in  1  system clock, all state changes on rising edge
clear  in  1  asynchronous, active-low reset
start  in  1  request to execute one instruction; sampled only in IDLE
opcode  in  OPW  ALU operation (encodings in package)
ra  in  4  destination register index
rb  in  4  first source index (loaded into Y)
rc  in  4  second source index (or sole source for unary ops)
Rout  out  NREG  one-hot register-to-bus enable (bit i = Ri out)
Rin  out  NREG  one-hot bus-to-register load (bit i = Ri in)
Yin  out  1  load Y from bus
ZHighin  out  1  load Z high half from ALU
Zlowin  out  1  load Z low half from ALU
Zhighout  out  1  Z high to bus
Zlowout  out  1  Z low to bus
HIin  out  1  load HI from bus
Loin  out  1  load LO from bus
op  out  OPW  ALU op code to data_path
busy  out  1  high from the cycle after acceptance until return to IDLE
done  out  1  one-cycle pulse in DONE state
err  out  1  one-cycle pulse when start is refused for an illegal opcode

Behaviour:
- Reset (clear=0, any time, including mid-instruction):
  - State goes to IDLE immediately.
  - All outputs are 0: Rout, Rin, op, strobes, busy, done, err.
  - Captured fields are cleared.
- Outputs are Moore, registered or decoded purely from the state register plus captured fields. No combinational path from inputs to outputs.
- IDLE with start=1 and legal opcode:
  - Capture opcode, ra, rb and rc.
  - Next state is T_Y for binary ops, T_OP for unary ops (NEG, NOT).
- IDLE with start=1 and illegal opcode (>OP_NOT): stay in IDLE, err=1 for the next cycle.
- start while busy is ignored; it is not queued.
- States and asserted outputs (each held exactly one cycle):
  - IDLE: all 0.
  - T_Y: Rout[rb]=1, Yin=1.
  - T_OP: Rout[rc]=1, op=opcode, ZHighin=1, Zlowin=1. op=0 in every other state.
  - T_LO: Zlowout=1. Wide ops (MUL, DIV) assert Loin=1; all other ops assert Rin[ra]=1.
  - T_HI: entered only for MUL/DIV. Zhighout=1, HIin=1.
  - DONE: done=1. Next state is IDLE.
- Transitions:
  - T_Y -> T_OP.
  - T_OP -> T_LO.
  - T_LO -> T_HI if the op is wide, else DONE.
  - T_HI -> DONE.
- Latency from the accepting edge to the done cycle, inclusive: binary 4, unary 3, wide 5. busy is high in every non-IDLE state.
- Invariants:
  - At most one bit of Rout is set.
  - At most one bus driver is active in any cycle (Rout, Zhighout, Zlowout are mutually exclusive).
  - Index 0 is a legal source or destination with no special casing; ra may equal rb or rc.
- Back-to-back: start held high is accepted on the edge leaving DONE->IDLE+1, i.e. the first IDLE cycle. Minimum one IDLE cycle between instructions.

Decomposition:
- Package alu_ctrl_pkg holds:
  - Op-code constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SHR=4, OP_SRA=5, OP_SHL=6, OP_ROR=7, OP_ROL=8, OP_MUL=9, OP_DIV=10, OP_NEG=11, OP_NOT=12.
  - State encoding, 3 bits.
  - Helper functions is_unary and is_wide.
- Sub-module onehot_dec16: 4-bit index plus enable to NREG one-hot. Instantiated twice, once for Rout and once for Rin.

Test Plan:
1. Reset mid-operation: clear low during T_OP -> all outputs 0 the same cycle; IDLE after release; the next start executes normally.
2. SRA, rb=1, rc=2, ra=3, start one cycle:
   - Next 4 cycles: Rout=0x0002/Yin; Rout=0x0004/op=5/ZHighin/Zlowin; Zlowout/Rin=0x0008; done.
   - busy high for exactly 4 cycles.
   - With data_path, Y=-12, R2=-5 -> R3=-12>>>(-5 low bits) per ALU definition.
3. MUL, rb=4, rc=5: T_LO asserts Loin with Rin=0; T_HI asserts Zhighout and HIin; done on cycle 5; no Rin bit ever set.
4. NOT, rc=7, ra=7: T_Y skipped; Rout=0x0080 with op=12; then Rin=0x0080; done on cycle 3.
5. opcode=5'b11111 with start -> err pulse one cycle, busy stays 0, no strobes.
6. start held high across two ADD instructions; opcode/ra changed while busy -> the first instruction uses captured fields, the second is accepted in the first IDLE cycle; checker confirms one-hot and single-bus-driver invariants every cycle.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module  : alu_ctrl_pkg
// Brief   : Op-code constants, FSM state encoding and op classification helpers
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB = 5'd1;
  localparam logic [OP_W-1:0] OP_AND = 5'd2;
  localparam logic [OP_W-1:0] OP_OR  = 5'd3;
  localparam logic [OP_W-1:0] OP_SHR = 5'd4;
  localparam logic [OP_W-1:0] OP_SRA = 5'd5;
  localparam logic [OP_W-1:0] OP_SHL = 5'd6;
  localparam logic [OP_W-1:0] OP_ROR = 5'd7;
  localparam logic [OP_W-1:0] OP_ROL = 5'd8;
  localparam logic [OP_W-1:0] OP_MUL = 5'd9;
  localparam logic [OP_W-1:0] OP_DIV = 5'd10;
  localparam logic [OP_W-1:0] OP_NEG = 5'd11;
  localparam logic [OP_W-1:0] OP_NOT = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T_Y  = 3'd1,
    ST_T_OP = 3'd2,
    ST_T_LO = 3'd3,
    ST_T_HI = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_wide(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_dec16.sv
// ============================================================================
// Module  : onehot_dec16
// Brief   : 4-bit index plus enable to NREG-wide one-hot strobe vector
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_dec16 #(
  parameter int NREG = 16
) (
  input  logic [3:0]      idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  assign onehot_o = en_i ? (NREG'(1) << idx_i) : '0;

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module  : alu_op_sequencer
// Brief   : Moore FSM sequencing one register-to-register ALU instruction
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic            Yin,
  output logic            ZHighin,
  output logic            Zlowin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            HIin,
  output logic            Loin,
  output logic [OPW-1:0]  op,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   opc_q, opc_d;
  logic [3:0]       ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  logic             rout_en_q, rin_en_q;
  logic [3:0]       rout_idx_q;
  logic             yin_q, zin_q, zlo_out_q, zhi_out_q, loin_q;
  logic [OPW-1:0]   op_q;
  logic             busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_legal(opcode)) begin
          opc_d   = opcode;
          ra_d    = ra;
          rb_d    = rb;
          rc_d    = rc;
          state_d = is_unary(opcode) ? ST_T_OP : ST_T_Y;
        end
      end
      ST_T_Y:  state_d = ST_T_OP;
      ST_T_OP: state_d = ST_T_LO;
      ST_T_LO: state_d = is_wide(opc_q) ? ST_T_HI : ST_DONE;
      ST_T_HI: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state cycle.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      opc_q      <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      rout_en_q  <= 1'b0;
      rout_idx_q <= '0;
      rin_en_q   <= 1'b0;
      yin_q      <= 1'b0;
      zin_q      <= 1'b0;
      zlo_out_q  <= 1'b0;
      zhi_out_q  <= 1'b0;
      loin_q     <= 1'b0;
      op_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rc_q       <= rc_d;
      rout_en_q  <= (state_d == ST_T_Y) || (state_d == ST_T_OP);
      rout_idx_q <= (state_d == ST_T_Y) ? rb_d : rc_d;
      rin_en_q   <= (state_d == ST_T_LO) && !is_wide(opc_d);
      yin_q      <= (state_d == ST_T_Y);
      zin_q      <= (state_d == ST_T_OP);
      zlo_out_q  <= (state_d == ST_T_LO);
      zhi_out_q  <= (state_d == ST_T_HI);
      loin_q     <= (state_d == ST_T_LO) && is_wide(opc_d);
      op_q       <= (state_d == ST_T_OP) ? opc_d : '0;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
      err_q      <= (state_q == ST_IDLE) && start && !is_legal(opcode);
    end
  end

  onehot_dec16 #(.NREG(NREG)) u_rout_dec (
    .idx_i    (rout_idx_q),
    .en_i     (rout_en_q),
    .onehot_o (Rout)
  );

  onehot_dec16 #(.NREG(NREG)) u_rin_dec (
    .idx_i    (ra_q),
    .en_i     (rin_en_q),
    .onehot_o (Rin)
  );

  assign Yin      = yin_q;
  assign ZHighin  = zin_q;
  assign Zlowin   = zin_q;
  assign Zhighout = zhi_out_q;
  assign HIin     = zhi_out_q;
  assign Zlowout  = zlo_out_q;
  assign Loin     = loin_q;
  assign op       = op_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module  : tb_alu_op_sequencer
// Brief   : Scoreboard bench for alu_op_sequencer with directed instructions
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [15:0] Rout, Rin;
  logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, Loin;
  logic [4:0]  op;
  logic        busy, done, err;

  int          n_checks = 0;
  int          n_errors = 0;
  bit          run = 1'b0;
  logic [46:0] exp_q[$];

  alu_op_sequencer #(.NREG(16), .OPW(5)) dut (
    .Clock(clk), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .Rout(Rout), .Rin(Rin), .Yin(Yin),
    .ZHighin(ZHighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIin(HIin), .Loin(Loin), .op(op), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [46:0] pack_out();
    return {Rout, Rin, Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, Loin,
            op, busy, done, err};
  endfunction

  // zin drives ZHighin/Zlowin together, zhi drives Zhighout/HIin together
  function automatic logic [46:0] mk(input logic [15:0] rout, input logic [15:0] rin,
                                     input logic yin, input logic zin, input logic zlo,
                                     input logic zhi, input logic loin, input logic [4:0] opv,
                                     input logic bsy, input logic dn, input logic er);
    return {rout, rin, yin, zin, zin, zhi, zlo, zhi, loin, opv, bsy, dn, er};
  endfunction

  task automatic check(input string name, input logic [46:0] act, input logic [46:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pop on every presented output, zero-check idle cycles, invariants always
  always @(negedge clk) begin
    if (run) begin
      logic [46:0] act;
      int drivers;
      act = pack_out();
      drivers = int'(Rout != 16'h0) + int'(Zhighout) + int'(Zlowout);
      n_checks++;
      if ($countones(Rout) > 1 || drivers > 1) begin
        n_errors++;
        $display("FAIL bus_invariant: got Rout=%h Zhighout=%b Zlowout=%b required one-hot single driver",
                 Rout, Zhighout, Zlowout);
      end
      if (busy || err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h expected idle", act);
        end else begin
          check("sequence", act, exp_q.pop_front());
        end
      end else begin
        check("idle_zero", act, 47'h0);
      end
    end
  end

  task automatic issue(input logic [4:0] opc, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c);
    @(negedge clk);
    start = 1'b1; opcode = opc; ra = a; rb = b; rc = c;
    @(negedge clk);
    start = 1'b0; opcode = 5'h1f; ra = 4'hf; rb = 4'hf; rc = 4'hf;
  endtask

  task automatic drain(input string name);
    repeat (7) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d pending entries required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", pack_out(), 47'h0);
    @(negedge clk);
    clear = 1'b1;
    run = 1'b1;

    // Reset during T_OP of an ADD
    exp_q.push_back(mk(16'h0040, 16'h0, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0));
    issue(5'd0, 4'd5, 4'd6, 4'd6);
    @(posedge clk);
    #2 clear = 1'b0;
    #1 check("reset_mid_op", pack_out(), 47'h0);
    exp_q.delete();
    @(posedge clk);
    #1 check("reset_held", pack_out(), 47'h0);
    #1 clear = 1'b1;
    drain("reset");

    // SRA rb=1 rc=2 ra=3
    exp_q.push_back(mk(16'h0002, 16'h0000, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0004, 16'h0000, 0, 1, 0, 0, 0, 5'd5, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0008, 0, 0, 1, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0));
    issue(5'd5, 4'd3, 4'd1, 4'd2);
    drain("sra");

    // MUL rb=4 rc=5 ra=6
    exp_q.push_back(mk(16'h0010, 16'h0000, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0020, 16'h0000, 0, 1, 0, 0, 0, 5'd9, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 0, 1, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 1, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0));
    issue(5'd9, 4'd6, 4'd4, 4'd5);
    drain("mul");

    // DIV with index 15 sources
    exp_q.push_back(mk(16'h8000, 16'h0000, 1, 0, 0, 0, 0, 5'd0,  1, 0, 0));
    exp_q.push_back(mk(16'h4000, 16'h0000, 0, 1, 0, 0, 0, 5'd10, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 1, 0, 1, 5'd0,  1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 1, 0, 5'd0,  1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0,  1, 1, 0));
    issue(5'd10, 4'd13, 4'd15, 4'd14);
    drain("div");

    // NOT rc=7 ra=7
    exp_q.push_back(mk(16'h0080, 16'h0000, 0, 1, 0, 0, 0, 5'd12, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0080, 0, 0, 1, 0, 0, 5'd0,  1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0,  1, 1, 0));
    issue(5'd12, 4'd7, 4'd9, 4'd7);
    drain("not");

    // NEG with register 0 as source and destination
    exp_q.push_back(mk(16'h0001, 16'h0000, 0, 1, 0, 0, 0, 5'd11, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0001, 0, 0, 1, 0, 0, 5'd0,  1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0,  1, 1, 0));
    issue(5'd11, 4'd0, 4'd3, 4'd0);
    drain("neg0");

    // Illegal opcodes refused with a single err pulse
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0, 0, 0, 1));
    issue(5'h1f, 4'd1, 4'd2, 4'd3);
    drain("err31");
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0, 0, 0, 1));
    issue(5'd13, 4'd1, 4'd2, 4'd3);
    drain("err13");

    // Back-to-back: ADD r1=r2+r3, then fields change while busy to SUB r9=r10-r0
    exp_q.push_back(mk(16'h0004, 16'h0000, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0008, 16'h0000, 0, 1, 0, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0002, 0, 0, 1, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0));
    exp_q.push_back(mk(16'h0400, 16'h0000, 1, 0, 0, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0001, 16'h0000, 0, 1, 0, 0, 0, 5'd1, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0200, 0, 0, 1, 0, 0, 5'd0, 1, 0, 0));
    exp_q.push_back(mk(16'h0000, 16'h0000, 0, 0, 0, 0, 0, 5'd0, 1, 1, 0));
    @(negedge clk);
    start = 1'b1; opcode = 5'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(negedge clk);
    opcode = 5'd1; ra = 4'd9; rb = 4'd10; rc = 4'd0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    drain("b2b");

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
